monitor_arbiter: RTL
====================

# monitor_arbiter

Shares the CPU's byte-wide program/data memory between the `cpu` core and a debug/loader monitor (e.g. a UART command engine). In normal operation the CPU owns the memory. On monitor request the arbiter halts the CPU, grants the monitor single-byte read and write access through a req/ack handshake, and on release restarts the CPU with a synchronous reset at a monitor-supplied start address. The block sits between `cpu`, the RAM and the monitor, and also drives the CPU's `halt`, `reset` and `start_address` inputs.

## Interface
- addr_width, 9, memory address width (matches `cpu`)
- boot_addr, 0, CPU start address after `resetn`

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cpu_raddr  in  addr_width  CPU read address
- cpu_waddr  in  addr_width  CPU write address
- cpu_write  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data (CPU `mem_data_in`)
- cpu_halted  in  1  CPU halted status
- cpu_halt  out  1  halt request to CPU
- cpu_reset  out  1  synchronous, active-high reset to CPU
- cpu_start_address  out  addr_width  CPU restart address
- mem_raddr  out  addr_width  RAM read address
- mem_waddr  out  addr_width  RAM write address
- mem_write  out  1  RAM write strobe
- mem_data_in  out  8  RAM write data
- mem_data_out  in  8  RAM read data (also wired directly to the CPU)
- mon_acquire  in  1  one-cycle pulse: take memory from CPU
- mon_run  in  1  one-cycle pulse: release memory and restart CPU
- mon_start_address  in  addr_width  restart address, sampled with `mon_run`
- mon_req  in  1  access request, held until `mon_ack`
- mon_we  in  1  1 = write, 0 = read, held with `mon_req`
- mon_addr  in  addr_width  access address, held with `mon_req`
- mon_wdata  in  8  write data, held with `mon_req`
- mon_ack  out  1  one-cycle access-complete pulse
- mon_rdata  out  8  read data, valid when `mon_ack` = 1 and held until the next read
- mon_granted  out  1  monitor owns memory

## Operation
- States: RST1, RST2, RUN, HALTREQ, OWNED, RD1, RD2, WR, REL1, REL2.
- Reset (`resetn` = 0): state RST1. Outputs: `cpu_reset` = 1, `cpu_halt` = 0, `cpu_start_address` = boot_addr, `mem_write` = 0, `mem_raddr`/`mem_waddr`/`mem_data_in` = 0, `mon_ack` = 0, `mon_rdata` = 0, `mon_granted` = 0.
- RST1 -> RST2 -> RUN. `cpu_reset` stays 1 through RST2 and is 0 in RUN. The CPU therefore sees at least 2 reset clocks after `resetn` rises.
- RUN: memory outputs follow the CPU inputs combinationally (`mem_raddr` = `cpu_raddr`, and so on). `mon_req` and `mon_run` are ignored. `mon_acquire` moves the state to HALTREQ and sets `cpu_halt` = 1.
- HALTREQ: `mem_write` is forced to 0. `cpu_halt` stays 1. When `cpu_halted` = 1, the state moves to OWNED and `mon_granted` is set to 1.
- OWNED: memory outputs come from internal registers. `cpu_halt` stays 1.
  - `mon_req` with `mon_we` = 0: register `mem_raddr` <= `mon_addr`, go to RD1.
  - `mon_req` with `mon_we` = 1: register `mem_waddr` <= `mon_addr` and `mem_data_in` <= `mon_wdata`, go to WR.
  - `mon_run` with no `mon_req`: latch `cpu_start_address` <= `mon_start_address`, go to REL1.
  - `mon_acquire` is ignored.
- RD1 -> RD2. In RD2, `mon_rdata` <= `mem_data_out`, `mon_ack` pulses, and the state returns to OWNED.
- WR: `mem_write` = 1 for exactly one cycle, `mon_ack` pulses, and the state returns to OWNED.
- REL1: `cpu_reset` = 1, `cpu_halt` = 0, `mon_granted` = 0.
- REL2: `cpu_reset` stays 1.
- After REL2 the state moves to RUN with `cpu_reset` = 0. The CPU clears `halted` and fetches from `cpu_start_address`.
- Boundary rules:
  - `mon_req` and `mon_run` in the same OWNED cycle: the request is served and `mon_run` is dropped; the monitor must reissue it.
  - `mon_run` during RD1, RD2 or WR is dropped.
  - `mon_acquire` outside RUN is dropped.
- Acquisition is abortive: a CPU multi-byte store in progress may be left partially written. This is accepted; the monitor acquires only for load and debug.
- `resetn` asserted in any state, including mid-access, forces RST1 immediately. Any pending `mon_ack` is lost.

## Timing
- Acquire latency: `mon_acquire` at cycle 0 gives `cpu_halt` = 1 at cycle 1. The CPU raises `cpu_halted` 2 cycles later, and `mon_granted` = 1 one cycle after `cpu_halted` is seen (typically cycle 4).
- Read: `mon_req` sampled at cycle 0 gives `mon_ack` with valid `mon_rdata` at cycle 3. This is the same 2-cycle RAM latency the CPU uses.
- Write: `mon_req` sampled at cycle 0 gives `mem_write` and `mon_ack` both at cycle 1.
- Back-to-back requests: the next `mon_req` is accepted on the cycle after `mon_ack`. Throughput is 1 read per 4 cycles and 1 write per 2 cycles.
- Release: `mon_run` at cycle 0 gives `cpu_reset` = 1 at cycles 1 and 2, RUN at cycle 3, and the first CPU fetch address at cycle 4.

## Test plan
- Power-up: hold `resetn` low for 3 cycles, then release -> `cpu_reset` is 1 for 2 more cycles, then 0. `cpu_start_address` = 0. The CPU fetches address 0.
- Acquire and write: while the CPU loops, pulse `mon_acquire`, then write 0xA5 to 0x010 -> `cpu_halt` = 1, `mon_granted` = 1 after `cpu_halted`, a single `mem_write` pulse with `mem_waddr` = 0x010 and `mem_data_in` = 0xA5, and `mon_ack` 1 cycle after the request.
- Read back: read 0x010 -> `mon_ack` 3 cycles after `mon_req`, with `mon_rdata` = 0xA5. `cpu_write` toggled by the bench during OWNED never reaches `mem_write`.
- Release: pulse `mon_run` with `mon_start_address` = 0x020 -> `cpu_reset` is high for exactly 2 cycles, `mon_granted` = 0, and the CPU's first `mem_raddr` = 0x020.
- Collisions: `mon_req` and `mon_run` in the same cycle -> the access completes and the CPU stays halted. `mon_acquire` while OWNED -> no state change.
- Reset mid-read: drop `resetn` in RD1 -> no `mon_ack`, all outputs at reset values, and the sequence restarts from RST1.

Source files
------------

// File: rtl/monitor_arbiter.sv
// monitor_arbiter: shares the CPU memory with a debug monitor, halting the CPU
// while the monitor owns it and restarting it at a chosen address on release.
module monitor_arbiter #(
  parameter int addr_width = 9,
  parameter logic [addr_width-1:0] boot_addr = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [addr_width-1:0] cpu_raddr,
  input  logic [addr_width-1:0] cpu_waddr,
  input  logic                  cpu_write,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_halted,
  output logic                  cpu_halt,
  output logic                  cpu_reset,
  output logic [addr_width-1:0] cpu_start_address,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  input  logic                  mon_acquire,
  input  logic                  mon_run,
  input  logic [addr_width-1:0] mon_start_address,
  input  logic                  mon_req,
  input  logic                  mon_we,
  input  logic [addr_width-1:0] mon_addr,
  input  logic [7:0]            mon_wdata,
  output logic                  mon_ack,
  output logic [7:0]            mon_rdata,
  output logic                  mon_granted
);
  typedef enum logic [3:0] {RST1, RST2, RUN, HALTREQ, OWNED, RD1, RD2, WR, REL1, REL2} state_t;
  state_t state;
  logic [addr_width-1:0] raddr_r, waddr_r;
  logic [7:0] wdata_r;
  logic write_r, pass, req;
  // a request still held in its ack cycle is the one just served, not a new one
  assign req = mon_req && !mon_ack;
  assign pass = state == RUN || state == HALTREQ;
  assign mem_raddr = pass ? cpu_raddr : raddr_r;
  assign mem_waddr = pass ? cpu_waddr : waddr_r;
  assign mem_data_in = pass ? cpu_wdata : wdata_r;
  assign mem_write = state == RUN ? cpu_write : write_r;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RST1;
      cpu_halt <= 1'b0;
      cpu_reset <= 1'b1;
      cpu_start_address <= boot_addr;
      raddr_r <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
      write_r <= 1'b0;
      mon_ack <= 1'b0;
      mon_rdata <= '0;
      mon_granted <= 1'b0;
    end else begin
      mon_ack <= 1'b0;
      write_r <= 1'b0;
      case (state)
        RST1: state <= RST2;
        RST2: begin
          cpu_reset <= 1'b0;
          state <= RUN;
        end
        RUN: if (mon_acquire) begin
          cpu_halt <= 1'b1;
          state <= HALTREQ;
        end
        HALTREQ: if (cpu_halted) begin
          mon_granted <= 1'b1;
          state <= OWNED;
        end
        OWNED: if (req && !mon_we) begin
          raddr_r <= mon_addr;
          state <= RD1;
        end else if (req) begin
          waddr_r <= mon_addr;
          wdata_r <= mon_wdata;
          write_r <= 1'b1;
          mon_ack <= 1'b1;
          state <= WR;
        end else if (mon_run) begin
          cpu_start_address <= mon_start_address;
          cpu_reset <= 1'b1;
          cpu_halt <= 1'b0;
          mon_granted <= 1'b0;
          state <= REL1;
        end
        RD1: state <= RD2;
        RD2: begin
          mon_rdata <= mem_data_out;
          mon_ack <= 1'b1;
          state <= OWNED;
        end
        WR: state <= OWNED;
        REL1: state <= REL2;
        REL2: begin
          cpu_reset <= 1'b0;
          state <= RUN;
        end
        default: state <= RST1;
      endcase
    end
  end
endmodule
